sal_rw_sched: RTL and testbench
===============================

# sal_rw_sched

Read/write command scheduler between the AXI front-end request path and the DRAM command scheduler of `SAL_DDR_CTRL`.
- Reads pass through directly, with no queue.
- Writes are buffered in a small write queue and drained in batches under high/low watermark control.
- Idle turnaround cycles are inserted on every read↔write direction switch to model bus turnaround.
- Any read whose address matches a queued write is held until that write is issued (RAW hazard protection).

## Interface
Parameters:
- `ADDR_W`, 32, request address width
- `WQ_DEPTH`, 8, write-queue entries, power of two, ≥2
- `HI_WM`, 6, queue occupancy that forces a write drain, `LO_WM` < `HI_WM` ≤ `WQ_DEPTH`
- `LO_WM`, 2, occupancy at or below which a drain may yield to reads
- `TURN_CYC`, 4, idle cycles per direction switch, ≥1

Ports:
- `clk`  in  1  clock; single clock domain, all logic on the rising edge
- `rst`  in  1  asynchronous, active-high reset
- `rd_valid`  in  1  read request valid
- `rd_ready`  out  1  read request accepted
- `rd_addr`  in  `ADDR_W`  read address
- `wr_valid`  in  1  write request valid
- `wr_ready`  out  1  write queue can accept
- `wr_addr`  in  `ADDR_W`  write address
- `cmd_valid`  out  1  command to DRAM scheduler valid
- `cmd_ready`  in  1  DRAM scheduler accepts command
- `cmd_wr`  out  1  1 = write command, 0 = read command
- `cmd_addr`  out  `ADDR_W`  command address
- `wq_cnt`  out  `$clog2(WQ_DEPTH)+1`  write-queue occupancy (registered)
- `drain`  out  1  1 while in the `RD2WR` or `WR` state

## Operation
- **Write queue:** FIFO of addresses.
  - `wr_ready = !rst && wq_cnt < WQ_DEPTH`. There is no same-cycle bypass when full.
  - A push and a pop in the same cycle leave `wq_cnt` unchanged.
- **Hazard:** `hazard = rd_valid` and `rd_addr` equals the address of any occupied queue entry. The comparison is combinational over all entries.
- **FSM states:** `RD` (reset state), `RD2WR`, `WR`, `WR2RD`.
- **`RD` state:**
  - `cmd_valid = rd_valid & !hazard`, `cmd_wr = 0`, `cmd_addr = rd_addr`, `rd_ready = cmd_ready & !hazard`.
  - Go to `RD2WR` when `wq_cnt ≥ HI_WM`, or `hazard`, or (`wq_cnt > 0` and `!rd_valid`).
  - A read handshake in the transition cycle still completes.
- **`RD2WR` and `WR2RD` states:**
  - `cmd_valid = 0` and `rd_ready = 0` for exactly `TURN_CYC` cycles, counted by a turn counter.
  - Then move to `WR` or `RD` respectively.
- **`WR` state:**
  - `cmd_valid = wq_cnt > 0`, `cmd_wr = 1`, `cmd_addr` = queue head. A pop occurs on the handshake. `rd_ready = 0`.
  - Let `cnt_next` be `wq_cnt` after this cycle's push/pop. Go to `WR2RD` when `cnt_next == 0`, or (`cnt_next ≤ LO_WM` and `rd_valid` and no hazard against the post-pop queue).
  - Writes pushed during `WR` join the current drain.
- A hazard always resolves: the matching entry is drained before the FSM returns to `RD`.
- `cmd_addr` and `cmd_wr` are don't-care while `cmd_valid = 0`. They must hold stable while `cmd_valid & !cmd_ready`.
- **Reset** (asserted at any time, including mid-drain or mid-turnaround):
  - Queue is emptied, state goes to `RD`, turn counter is cleared. In-flight un-handshaked commands are dropped.
  - While `rst` is asserted: `cmd_valid = 0`, `rd_ready = 0`, `wr_ready = 0`, `wq_cnt = 0`, `drain = 0`.

## Timing
- **Read path:** combinational from `rd_*` to `cmd_*` in `RD`; zero-cycle latency.
- **Write path:** an entry pushed at edge N is visible at the queue head and counted in `wq_cnt` from cycle N+1.
- **Direction switch:** a state change takes effect at the next edge. The first command in the new direction appears `TURN_CYC` cycles after entering the turnaround state.
- **Minimum write latency** from an idle `RD` state: 1 (push) + 1 (`RD→RD2WR`) + `TURN_CYC` cycles.

## Structure
- Package `sal_sched_pkg`:
  - `sched_state_t` enum (`RD`, `RD2WR`, `WR`, `WR2RD`).
  - Default parameter constants.
- Sub-module `sal_wq_fifo`:
  - Address FIFO with per-entry occupied bits.
  - Outputs: head address, count, `match` for a compare address.
- The FSM, turn counter and muxing stay in `sal_rw_sched`.

## Test plan
- **Read-only traffic:** 10 back-to-back reads with `cmd_ready = 1` → 10 read commands on consecutive cycles, same cycle as `rd_valid`; `drain` stays 0.
- **Idle write:** single write to 0x40 with no reads → `cmd_valid` with `cmd_wr = 1`, `cmd_addr = 0x40` exactly 6 cycles after the push handshake; then `WR2RD`, then `RD`; `wq_cnt` returns to 0.
- **High-watermark drain:**
  - Stimulus: continuous reads, plus 6 writes pushed.
  - When `wq_cnt` reaches 6 → reads stall; after 4 idle cycles, 4 writes issue (`cnt_next = 2 ≤ LO_WM`); after 4 idle cycles, reads resume.
- **RAW hazard:** write to 0x100 queued, then read to 0x100 in `RD` → `rd_ready = 0` and a forced drain; the read issues only after write 0x100 is popped plus 4 turnaround cycles.
- **Full queue with back-pressure:** `cmd_ready = 0` and 8 writes → `wr_ready` drops at `wq_cnt = 8`; a ninth write is held; `cmd_addr` stays stable.
- **Mid-drain reset:** assert `rst` during `WR` with `wq_cnt = 5` → outputs immediately take their reset values; after release, state is `RD`, `wq_cnt = 0`, and no stale write is ever issued.

Source files
------------

// File: rtl/sal_sched_pkg.sv
// Shared types and default parameters for the read/write command scheduler.
package sal_sched_pkg;

  localparam int unsigned DEF_ADDR_W   = 32;
  localparam int unsigned DEF_WQ_DEPTH = 8;
  localparam int unsigned DEF_HI_WM    = 6;
  localparam int unsigned DEF_LO_WM    = 2;
  localparam int unsigned DEF_TURN_CYC = 4;

  typedef enum logic [1:0] {
    RD    = 2'd0,
    RD2WR = 2'd1,
    WR    = 2'd2,
    WR2RD = 2'd3
  } sched_state_t;

endpackage

// File: rtl/sal_rw_sched_if.sv
// Request/command bundle between the AXI front-end, the scheduler and the DRAM command path.
interface sal_rw_sched_if
  import sal_sched_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned WQ_DEPTH = DEF_WQ_DEPTH
);
  localparam int unsigned CNT_W = $clog2(WQ_DEPTH) + 1;

  logic              rd_valid;
  logic              rd_ready;
  logic [ADDR_W-1:0] rd_addr;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_wr;
  logic [ADDR_W-1:0] cmd_addr;
  logic [CNT_W-1:0]  wq_cnt;
  logic              drain;

  modport master (
    output rd_valid, rd_addr, wr_valid, wr_addr, cmd_ready,
    input  rd_ready, wr_ready, cmd_valid, cmd_wr, cmd_addr, wq_cnt, drain
  );

  modport slave (
    input  rd_valid, rd_addr, wr_valid, wr_addr, cmd_ready,
    output rd_ready, wr_ready, cmd_valid, cmd_wr, cmd_addr, wq_cnt, drain
  );

endinterface

// File: rtl/sal_wq_fifo.sv
// Write-address FIFO with per-entry occupied bits and a parallel address compare.
module sal_wq_fifo
  import sal_sched_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DEPTH  = DEF_WQ_DEPTH,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic              pop,
  input  logic [ADDR_W-1:0] cmp_addr,
  output logic [ADDR_W-1:0] head,
  output logic [CNT_W-1:0]  cnt,
  output logic              match,
  output logic              match_rest
);

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  occ;
  logic [PTR_W-1:0]  wptr, rptr;
  logic [CNT_W-1:0]  cnt_q;

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= push_addr;
  end

  // Caller guarantees no push when full and no pop when empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ   <= '0;
      wptr  <= '0;
      rptr  <= '0;
      cnt_q <= '0;
    end else begin
      if (pop) begin
        occ[rptr] <= 1'b0;
        rptr      <= rptr + PTR_W'(1);
      end
      if (push) begin
        occ[wptr] <= 1'b1;
        wptr      <= wptr + PTR_W'(1);
      end
      cnt_q <= cnt_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // match_rest ignores the head so the caller can see the queue as it will be after a pop.
  always_comb begin
    match      = 1'b0;
    match_rest = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (occ[i] && (mem[i] == cmp_addr)) begin
        match = 1'b1;
        if (PTR_W'(i) != rptr) match_rest = 1'b1;
      end
    end
  end

  assign head = mem[rptr];
  assign cnt  = cnt_q;

endmodule

// File: rtl/sal_rw_sched.sv
// Read/write command scheduler: read pass-through, watermark-driven write drains,
// bus-turnaround idles and read-after-write hazard holds.
module sal_rw_sched
  import sal_sched_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned WQ_DEPTH = DEF_WQ_DEPTH,
  parameter int unsigned HI_WM    = DEF_HI_WM,
  parameter int unsigned LO_WM    = DEF_LO_WM,
  parameter int unsigned TURN_CYC = DEF_TURN_CYC
) (
  input  logic           clk,
  input  logic           rst,
  sal_rw_sched_if.slave  bus
);

  localparam int unsigned CNT_W  = $clog2(WQ_DEPTH) + 1;
  localparam int unsigned TURN_W = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;

  sched_state_t      state_q, state_d;
  logic [TURN_W-1:0] turn_q, turn_d;

  logic [CNT_W-1:0]  cnt, cnt_next;
  logic [ADDR_W-1:0] head;
  logic              match, match_rest, hazard;
  logic              push, pop, wr_ready;
  logic              cmd_valid, cmd_wr, rd_ready;
  logic [ADDR_W-1:0] cmd_addr;

  assign wr_ready = !rst && (cnt < CNT_W'(WQ_DEPTH));
  assign push     = bus.wr_valid & wr_ready;
  assign hazard   = bus.rd_valid & match;

  sal_wq_fifo #(
    .ADDR_W (ADDR_W),
    .DEPTH  (WQ_DEPTH)
  ) u_wq (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_addr  (bus.wr_addr),
    .pop        (pop),
    .cmp_addr   (bus.rd_addr),
    .head       (head),
    .cnt        (cnt),
    .match      (match),
    .match_rest (match_rest)
  );

  // State and turnaround counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RD;
      turn_q  <= '0;
    end else begin
      state_q <= state_d;
      turn_q  <= turn_d;
    end
  end

  // Next state and command muxing.
  always_comb begin
    state_d   = state_q;
    turn_d    = turn_q;
    cmd_valid = 1'b0;
    cmd_wr    = 1'b0;
    cmd_addr  = bus.rd_addr;
    rd_ready  = 1'b0;
    pop       = 1'b0;
    cnt_next  = cnt;

    case (state_q)
      RD: begin
        cmd_valid = bus.rd_valid & !hazard;
        rd_ready  = bus.cmd_ready & !hazard;
        if ((cnt >= CNT_W'(HI_WM)) || hazard || ((cnt != '0) && !bus.rd_valid))
          state_d = RD2WR;
      end
      RD2WR, WR2RD: begin
        if (turn_q == TURN_W'(TURN_CYC - 1)) begin
          turn_d  = '0;
          state_d = (state_q == RD2WR) ? WR : RD;
        end else begin
          turn_d = turn_q + TURN_W'(1);
        end
      end
      WR: begin
        cmd_valid = (cnt != '0);
        cmd_wr    = 1'b1;
        cmd_addr  = head;
        pop       = cmd_valid & bus.cmd_ready;
        cnt_next  = cnt + CNT_W'(push) - CNT_W'(pop);
        // Yield early only if the waiting read no longer collides with anything queued.
        if ((cnt_next == '0) ||
            ((cnt_next <= CNT_W'(LO_WM)) && bus.rd_valid && !(pop ? match_rest : match)))
          state_d = WR2RD;
      end
      default: state_d = RD;
    endcase

    if (rst) begin
      cmd_valid = 1'b0;
      rd_ready  = 1'b0;
      pop       = 1'b0;
    end
  end

  assign bus.cmd_valid = cmd_valid;
  assign bus.cmd_wr    = cmd_wr;
  assign bus.cmd_addr  = cmd_addr;
  assign bus.rd_ready  = rd_ready;
  assign bus.wr_ready  = wr_ready;
  assign bus.wq_cnt    = cnt;
  assign bus.drain     = !rst && ((state_q == RD2WR) || (state_q == WR));

endmodule

// File: tb/tb_sal_rw_sched.sv
// Directed, table-driven bench for sal_rw_sched with hand-computed cycle expectations.
module tb_sal_rw_sched;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  sal_rw_sched_if #(.ADDR_W(32), .WQ_DEPTH(8)) bus ();

  sal_rw_sched #(
    .ADDR_W(32), .WQ_DEPTH(8), .HI_WM(6), .LO_WM(2), .TURN_CYC(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        rd_valid;
    logic [31:0] rd_addr;
    logic        wr_valid;
    logic [31:0] wr_addr;
    logic        cmd_ready;
    logic        e_cmd_valid;
    logic        e_cmd_wr;
    logic [31:0] e_cmd_addr;
    logic        e_rd_ready;
    logic        e_wr_ready;
    logic [3:0]  e_wq_cnt;
    logic        e_drain;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rv, input logic [31:0] ra, input logic wv,
                              input logic [31:0] wa, input logic cr, input logic ecv,
                              input logic ecw, input logic [31:0] eca, input logic err,
                              input logic ewr, input logic [3:0] ecnt, input logic edr);
    vec_t v;
    v.rd_valid = rv;  v.rd_addr = ra;  v.wr_valid = wv;  v.wr_addr = wa;
    v.cmd_ready = cr; v.e_cmd_valid = ecv; v.e_cmd_wr = ecw; v.e_cmd_addr = eca;
    v.e_rd_ready = err; v.e_wr_ready = ewr; v.e_wq_cnt = ecnt; v.e_drain = edr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, check, then advance a cycle.
  task automatic apply(input vec_t v, input string tag);
    bus.rd_valid  = v.rd_valid;
    bus.rd_addr   = v.rd_addr;
    bus.wr_valid  = v.wr_valid;
    bus.wr_addr   = v.wr_addr;
    bus.cmd_ready = v.cmd_ready;
    #1;
    chk({tag, ".cmd_valid"}, 32'(bus.cmd_valid), 32'(v.e_cmd_valid));
    if (v.e_cmd_valid) begin
      chk({tag, ".cmd_wr"},   32'(bus.cmd_wr), 32'(v.e_cmd_wr));
      chk({tag, ".cmd_addr"}, bus.cmd_addr,    v.e_cmd_addr);
    end
    chk({tag, ".rd_ready"}, 32'(bus.rd_ready), 32'(v.e_rd_ready));
    chk({tag, ".wr_ready"}, 32'(bus.wr_ready), 32'(v.e_wr_ready));
    chk({tag, ".wq_cnt"},   32'(bus.wq_cnt),   32'(v.e_wq_cnt));
    chk({tag, ".drain"},    32'(bus.drain),    32'(v.e_drain));
    @(negedge clk);
  endtask

  // Empty the queue and return to RD, bounded.
  task automatic drain_all(input string tag);
    int n;
    n = 0;
    bus.rd_valid  = 1'b0;
    bus.wr_valid  = 1'b0;
    bus.cmd_ready = 1'b1;
    #1;
    while (((bus.wq_cnt != 4'd0) || bus.drain) && (n < 100)) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({tag, ".flush_done"}, 32'(n < 100), 32'd1);
    repeat (4) @(negedge clk);
    #1;
    chk({tag, ".flush_rd_ready"}, 32'(bus.rd_ready), 32'd1);
    chk({tag, ".flush_wq_cnt"},   32'(bus.wq_cnt),   32'd0);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [3:0]  c_exp;

    // Reset with active-looking inputs.
    rst = 1'b1;
    bus.rd_valid = 1'b1; bus.rd_addr = 32'h40;
    bus.wr_valid = 1'b1; bus.wr_addr = 32'h40;
    bus.cmd_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("reset.cmd_valid", 32'(bus.cmd_valid), 32'd0);
    chk("reset.rd_ready",  32'(bus.rd_ready),  32'd0);
    chk("reset.wr_ready",  32'(bus.wr_ready),  32'd0);
    chk("reset.wq_cnt",    32'(bus.wq_cnt),    32'd0);
    chk("reset.drain",     32'(bus.drain),     32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Table: 10 back-to-back reads, then a lone write from idle.
    for (int i = 0; i < 10; i++) begin
      a = 32'h1000 + 32'(i * 4);
      tbl.push_back(mk(1, a, 0, 0, 1,  1, 0, a, 1, 1, 4'd0, 0));
    end
    tbl.push_back(mk(0, 0, 1, 32'h40, 1,  0, 0, 0, 1, 1, 4'd0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1,       0, 0, 0, 1, 1, 4'd1, 0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0, 0, 0, 0, 1,     0, 0, 0, 0, 1, 4'd1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1,       1, 1, 32'h40, 0, 1, 4'd1, 1));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0, 0, 0, 0, 1,     0, 0, 0, 0, 1, 4'd0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1,       0, 0, 0, 1, 1, 4'd0, 0));

    for (int i = 0; i < tbl.size(); i++)
      apply(tbl[i], $sformatf("%s[%0d]", (i < 10) ? "rdonly" : "idlewr", i));

    // High-watermark drain under continuous reads.
    for (int c = 0; c < 20; c++) begin
      vec_t v;
      a = 32'h2000 + 32'(c * 4);
      if (c <= 6)       c_exp = 4'(c);
      else if (c <= 11) c_exp = 4'd6;
      else if (c <= 14) c_exp = 4'(17 - c);
      else              c_exp = 4'd2;
      v = mk(1, a, (c < 6), 32'h300 + 32'(c * 16), 1,  0, 0, 0, 0, 1, c_exp, 0);
      if (c <= 6 || c == 19) begin
        v.e_cmd_valid = 1; v.e_cmd_addr = a; v.e_rd_ready = 1;
      end else if (c <= 10) begin
        v.e_drain = 1;
      end else if (c <= 14) begin
        v.e_cmd_valid = 1; v.e_cmd_wr = 1; v.e_cmd_addr = 32'h300 + 32'((c - 11) * 16);
        v.e_drain = 1;
      end
      apply(v, $sformatf("hiwm[%0d]", c));
    end
    drain_all("hiwm");

    // RAW hazard: read of a queued address waits behind a non-matching older write.
    for (int c = 0; c < 14; c++) begin
      vec_t v;
      if (c == 0)      v = mk(1, 32'h500, 1, 32'h110, 1,  1, 0, 32'h500, 1, 1, 4'd0, 0);
      else if (c == 1) v = mk(1, 32'h504, 1, 32'h100, 1,  1, 0, 32'h504, 1, 1, 4'd1, 0);
      else if (c == 2) v = mk(1, 32'h100, 0, 0, 1,        0, 0, 0, 0, 1, 4'd2, 0);
      else if (c <= 6) v = mk(1, 32'h100, 0, 0, 1,        0, 0, 0, 0, 1, 4'd2, 1);
      else if (c == 7) v = mk(1, 32'h100, 0, 0, 1,        1, 1, 32'h110, 0, 1, 4'd2, 1);
      else if (c == 8) v = mk(1, 32'h100, 0, 0, 1,        1, 1, 32'h100, 0, 1, 4'd1, 1);
      else if (c <= 12) v = mk(1, 32'h100, 0, 0, 1,       0, 0, 0, 0, 1, 4'd0, 0);
      else             v = mk(1, 32'h100, 0, 0, 1,        1, 0, 32'h100, 1, 1, 4'd0, 0);
      apply(v, $sformatf("raw[%0d]", c));
    end
    drain_all("raw");

    // Full queue with command back-pressure, then release.
    for (int c = 0; c < 21; c++) begin
      vec_t v;
      logic        wv;
      logic [31:0] wa;
      wv = (c <= 13);
      wa = (c < 8) ? 32'h600 + 32'(c * 16) : 32'h680;
      if (c <= 8)       c_exp = 4'(c);
      else if (c <= 12) c_exp = 4'd8;
      else if (c <= 14) c_exp = 4'd7;
      else              c_exp = 4'(21 - c);
      v = mk(0, 0, wv, wa, (c >= 12),  (c >= 6), 1,
             (c <= 12) ? 32'h600 : 32'h600 + 32'((c - 12) * 16),
             0, !(c >= 8 && c <= 12), c_exp, (c >= 2));
      apply(v, $sformatf("full[%0d]", c));
    end
    drain_all("full");

    // Reset asserted mid-drain with five writes queued.
    for (int c = 0; c < 7; c++) begin
      c_exp = (c <= 5) ? 4'(c) : 4'd5;
      apply(mk(0, 0, (c < 5), 32'h700 + 32'(c * 16), 0,  (c == 6), 1, 32'h700,
               0, 1, c_exp, (c >= 2)), $sformatf("pre_rst[%0d]", c));
    end
    rst = 1'b1;
    bus.rd_valid = 1'b1; bus.rd_addr = 32'h9000;
    bus.wr_valid = 1'b1; bus.wr_addr = 32'h780;
    bus.cmd_ready = 1'b1;
    #1;
    chk("midrst.cmd_valid", 32'(bus.cmd_valid), 32'd0);
    chk("midrst.rd_ready",  32'(bus.rd_ready),  32'd0);
    chk("midrst.wr_ready",  32'(bus.wr_ready),  32'd0);
    chk("midrst.wq_cnt",    32'(bus.wq_cnt),    32'd0);
    chk("midrst.drain",     32'(bus.drain),     32'd0);
    @(negedge clk);
    #1;
    chk("midrst_hold.wq_cnt", 32'(bus.wq_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 10; c++)
      apply(mk(0, 0, 0, 0, 1,  0, 0, 0, 1, 1, 4'd0, 0), $sformatf("post_rst[%0d]", c));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
